// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use bubble, taken-branch flush, data-memory wait and timeout trap.
// Optional perf counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_ce,
  output logic        if_id_ce,
  output logic        id_ex_ce,
  output logic        ex_mem_ce,
  output logic        mem_wb_ce,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, TRAP = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic             memstall;
  logic             lu;

  assign memstall = mem_req & ~mem_ack;
  assign lu = ex_memread & (ex_rt != 5'd0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Everything holds while reset is asserted or the pipe is trapped.
  always_comb begin
    pc_ce       = 1'b0;
    if_id_ce    = 1'b0;
    id_ex_ce    = 1'b0;
    ex_mem_ce   = 1'b0;
    mem_wb_ce   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst && state != TRAP) begin
      if (memstall) begin
        pc_ce = 1'b0;
      end else if (ex_branch_taken) begin
        pc_ce       = 1'b1;
        if_id_ce    = 1'b1;
        id_ex_ce    = 1'b1;
        ex_mem_ce   = 1'b1;
        mem_wb_ce   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        id_ex_ce    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_ce   = 1'b1;
        mem_wb_ce   = 1'b1;
      end else begin
        pc_ce     = 1'b1;
        if_id_ce  = 1'b1;
        id_ex_ce  = 1'b1;
        ex_mem_ce = 1'b1;
        mem_wb_ce = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (memstall) begin
            wcnt <= wcnt + CNT_W'(1);
            // This stall cycle is the WAIT_MAX-th in a row.
            if (wcnt == CNT_W'(WAIT_MAX - 1)) begin
              state   <= TRAP;
              mem_err <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end else begin
            state <= RUN;
            wcnt  <= '0;
          end
        end
        default: begin
          state   <= TRAP;
          mem_err <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_ce && state != TRAP) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush | id_ex_flush) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; inputs change on negedge, outputs sampled shortly after.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ack;
  logic pc_ce, if_id_ce, id_ex_ce, ex_mem_ce, mem_wb_ce;
  logic if_id_flush, id_ex_flush, mem_err;
  logic [31:0] stall_cycles, flush_count;
  int vec = 0;
  int miss = 0;

  wire [4:0] ce = {pc_ce, if_id_ce, id_ex_ce, ex_mem_ce, mem_wb_ce};
  wire [1:0] fl = {if_id_flush, id_ex_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_ce(pc_ce), .if_id_ce(if_id_ce),
    .id_ex_ce(id_ex_ce), .ex_mem_ce(ex_mem_ce), .mem_wb_ce(mem_wb_ce),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    #3;
    vec++; if (ce !== 5'b00000 || fl !== 2'b00) begin miss++; $display("FAIL reset_out ce=%b fl=%b want 00000/00", ce, fl); end
    vec++; if (mem_err !== 1'b0 || dut.state !== 2'd0 || dut.wcnt !== 8'd0) begin miss++; $display("FAIL reset_state err=%b st=%0d wcnt=%0d want 0/0/0", mem_err, dut.state, dut.wcnt); end
    vec++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin miss++; $display("FAIL reset_perf %0d/%0d want 0/0", stall_cycles, flush_count); end
    @(negedge clk); rst = 1'b0;
    #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b00) begin miss++; $display("FAIL normal ce=%b fl=%b want 11111/00", ce, fl); end
  endtask

  task automatic test_load_use();
    @(negedge clk); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    vec++; if (ce !== 5'b00111 || fl !== 2'b01) begin miss++; $display("FAIL lu_rs ce=%b fl=%b want 00111/01", ce, fl); end
    @(negedge clk); idle(); #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b00) begin miss++; $display("FAIL lu_clear ce=%b fl=%b want 11111/00", ce, fl); end
    @(negedge clk); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b00) begin miss++; $display("FAIL lu_r0 ce=%b fl=%b want 11111/00", ce, fl); end
    @(negedge clk); ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1; #1;
    vec++; if (ce !== 5'b00111 || fl !== 2'b01) begin miss++; $display("FAIL lu_rt ce=%b fl=%b want 00111/01", ce, fl); end
    id_uses_rt = 1'b0; #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b00) begin miss++; $display("FAIL lu_rt_unused ce=%b fl=%b want 11111/00", ce, fl); end
    @(negedge clk); idle();
  endtask

  task automatic test_branch_lu();
    @(negedge clk); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1; #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b11) begin miss++; $display("FAIL br_lu ce=%b fl=%b want 11111/11", ce, fl); end
    @(negedge clk); idle(); #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b00) begin miss++; $display("FAIL br_after ce=%b fl=%b want 11111/00", ce, fl); end
  endtask

  task automatic test_mem_wait();
    @(negedge clk); mem_req = 1'b1; mem_ack = 1'b1; ex_branch_taken = 1'b1; #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b11) begin miss++; $display("FAIL single_cycle ce=%b fl=%b want 11111/11", ce, fl); end
    @(negedge clk); idle(); mem_req = 1'b1; ex_branch_taken = 1'b1; #1;
    vec++; if (ce !== 5'b00000 || fl !== 2'b00) begin miss++; $display("FAIL wait0 ce=%b fl=%b want 00000/00", ce, fl); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      vec++; if (dut.state !== 2'd1 || dut.wcnt !== 8'(k)) begin miss++; $display("FAIL wait_cnt%0d st=%0d wcnt=%0d want 1/%0d", k, dut.state, dut.wcnt, k); end
      if (k < 3) begin
        vec++; if (ce !== 5'b00000) begin miss++; $display("FAIL wait_ce%0d ce=%b want 00000", k, ce); end
      end
    end
    ex_branch_taken = 1'b0; mem_ack = 1'b1; #1;
    vec++; if (ce !== 5'b11111 || fl !== 2'b00) begin miss++; $display("FAIL ack_ce ce=%b fl=%b want 11111/00", ce, fl); end
    @(negedge clk); idle(); #1;
    vec++; if (dut.state !== 2'd0 || dut.wcnt !== 8'd0) begin miss++; $display("FAIL ack_state st=%0d wcnt=%0d want 0/0", dut.state, dut.wcnt); end
    mem_ack = 1'b1; #1;
    vec++; if (ce !== 5'b11111 || dut.state !== 2'd0) begin miss++; $display("FAIL lone_ack ce=%b st=%0d want 11111/0", ce, dut.state); end
    @(negedge clk); idle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1;
    for (int k = 1; k <= 14; k++) @(negedge clk);
    #1;
    vec++; if (mem_err !== 1'b0 || dut.wcnt !== 8'd14) begin miss++; $display("FAIL to_pre err=%b wcnt=%0d want 0/14", mem_err, dut.wcnt); end
    @(negedge clk); #1;
    vec++; if (mem_err !== 1'b1 || dut.state !== 2'd2 || ce !== 5'b00000) begin miss++; $display("FAIL to_trap err=%b st=%0d ce=%b want 1/2/00000", mem_err, dut.state, ce); end
    mem_ack = 1'b1; ex_branch_taken = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      vec++; if (mem_err !== 1'b1 || ce !== 5'b00000 || fl !== 2'b00) begin miss++; $display("FAIL trap_hold%0d err=%b ce=%b fl=%b want 1/00000/00", k, mem_err, ce, fl); end
    end
    do_reset(); #1;
    vec++; if (mem_err !== 1'b0 || ce !== 5'b11111) begin miss++; $display("FAIL trap_rst err=%b ce=%b want 0/11111", mem_err, ce); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); mem_req = 1'b1;
    @(negedge clk); @(negedge clk);
    mem_ack = 1'b1; #1;
    vec++; if (ce !== 5'b11111 || dut.state !== 2'd1) begin miss++; $display("FAIL ar_pre ce=%b st=%0d want 11111/1", ce, dut.state); end
    #1 rst = 1'b1; #1;
    vec++; if (ce !== 5'b00000 || dut.state !== 2'd0 || dut.wcnt !== 8'd0) begin miss++; $display("FAIL ar_mid ce=%b st=%0d wcnt=%0d want 00000/0/0", ce, dut.state, dut.wcnt); end
    @(negedge clk); rst = 1'b0; idle(); #1;
    vec++; if (ce !== 5'b11111 || dut.state !== 2'd0 || dut.wcnt !== 8'd0) begin miss++; $display("FAIL ar_post ce=%b st=%0d wcnt=%0d want 11111/0/0", ce, dut.state, dut.wcnt); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_s, exp_f;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    exp_s = 32'd5; exp_f = 32'd3;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      @(negedge clk); idle();
      @(negedge clk);
    end
    mem_req = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk); idle(); ex_branch_taken = 1'b1;
    @(negedge clk); idle(); #1;
    vec++; if (stall_cycles !== exp_s) begin miss++; $display("FAIL perf_stall got %0d want %0d", stall_cycles, exp_s); end
    vec++; if (flush_count !== exp_f) begin miss++; $display("FAIL perf_flush got %0d want %0d", flush_count, exp_f); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Drives the clock-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazards: load-use, taken branch, and multi-cycle data-memory access via a req/ack handshake.
- Includes a watchdog that traps a memory access that never completes.

Parameters:
- WAIT_MAX, 15, maximum consecutive data-memory wait cycles before trap (1..255).
- CNT_W, 8, width of the memory-wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  5  destination of the EX load.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage is accessing data memory this cycle.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_ce  out  1  PC update enable.
- if_id_ce  out  1  IF/ID register enable.
- id_ex_ce  out  1  ID/EX register enable.
- ex_mem_ce  out  1  EX/MEM register enable.
- mem_wb_ce  out  1  MEM/WB register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble (all control bits 0) into ID/EX.
- mem_err  out  1  sticky memory-timeout trap flag.
- stall_cycles  out  32  perf counter (see Optional Feature).
- flush_count  out  32  perf counter (see Optional Feature).

Behaviour:
- State register: RUN, MEM_WAIT, TRAP (2 bits). The wait counter wcnt is CNT_W bits.
- Outputs are combinational (Mealy) from state plus current inputs. Flush outputs take effect at the next posedge together with the enables.
- Reset (async, rst=1):
  - state=RUN, wcnt=0, mem_err=0, perf counters=0.
  - While rst is high, all ce=0 and both flush outputs=0.
- Hazard terms:
  - memstall = mem_req & ~mem_ack.
  - lu = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
- Priority in RUN and MEM_WAIT: memstall > ex_branch_taken > lu > normal.
- memstall:
  - All five ce=0; flushes=0. The whole pipe freezes, so MEM/WB does not re-capture.
  - The next state is MEM_WAIT and wcnt increments.
- ex_branch_taken (no memstall):
  - All ce=1, if_id_flush=1, id_ex_flush=1, so 2-cycle branch penalty.
  - Branch wins over lu on the same cycle, because the ID instruction is wrong-path.
- lu (no memstall, no branch):
  - pc_ce=0, if_id_ce=0, id_ex_ce=1 with id_ex_flush=1, ex_mem_ce=1, mem_wb_ce=1.
  - Exactly one bubble is inserted. lu clears naturally the next cycle because EX then holds the bubble.
- Normal: all ce=1, flushes=0.
- MEM_WAIT:
  - Same output rules as RUN.
  - When mem_ack=1 (memstall=0): return to RUN and clear wcnt. The pipe advances on this same cycle.
  - If wcnt reaches WAIT_MAX while memstall is still 1: go to TRAP and set mem_err=1.
- TRAP:
  - All ce=0, flushes=0, mem_err=1. Only rst exits TRAP.
- Reset mid-stall: reset forces RUN immediately; an outstanding mem_req is abandoned.
- mem_ack without mem_req is ignored.
- A single-cycle access (mem_req=1, mem_ack=1 on the same cycle) causes no stall.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_ce=0 outside TRAP and reset.
  - flush_count increments on every cycle with if_id_flush|id_ex_flush.
  - Both counters wrap at 2^32 and are cleared by rst.
- Undefined: both ports are driven constant 0 and no counter flops are synthesized.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle.
  - Required: pc_ce=0, if_id_ce=0, id_ex_flush=1, ex_mem_ce=1, mem_wb_ce=1 for exactly one cycle.
  - Repeat with ex_rt=0: no stall.
- Branch plus load-use on the same cycle: ex_branch_taken=1, lu=1 -> all ce=1, if_id_flush=1, id_ex_flush=1, no stall.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1.
  - Required: all ce=0 for 3 cycles; state=MEM_WAIT with wcnt 1,2,3.
  - On the ack cycle: all ce=1 and state=RUN next.
- Timeout: mem_req=1, mem_ack held 0 with WAIT_MAX=15 -> mem_err=1 after the 15th wait cycle, all ce=0.
  - Required: remains so through 10 further cycles with mem_ack=1; rst pulse clears mem_err=0 and ce=1.
- Async reset mid-MEM_WAIT: assert rst between clock edges -> all ce drop to 0 immediately; after release, state=RUN and wcnt=0.
- PERF_EN: 2 load-use stalls, 3 memory-wait cycles and 1 branch -> stall_cycles=5, flush_count=3.
  - With the macro undefined, both outputs read 0.
